// File: rtl/icache_line_responder_pkg.sv
// Shared widths and FSM encoding for the direct-mapped instruction cache line responder.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

package icache_line_responder_pkg;

    localparam int ICACHE_LINE_BITS   = 128;
    localparam int ICACHE_LINE_WORDS  = 4;
    localparam int ICACHE_OFFSET_BITS = 4;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOOKUP      = 3'd1,
        ST_REFILL_REQ  = 3'd2,
        ST_REFILL_DATA = 3'd3,
        ST_RESP        = 3'd4
    } ic_state_e;

endpackage

// File: rtl/icache_line_responder_tag_data_array.sv
// Tag and line storage for the instruction cache: combinational read, synchronous write.
module icache_tag_data_array
    import icache_line_responder_pkg::*;
#(
    parameter int NUM_SETS   = 64,
    parameter int INDEX_BITS = $clog2(NUM_SETS),
    parameter int TAG_BITS   = 22
) (
    input  logic                        clk,
    input  logic                        we_i,
    input  logic [INDEX_BITS-1:0]       windex_i,
    input  logic [TAG_BITS-1:0]         wtag_i,
    input  logic [ICACHE_LINE_BITS-1:0] wdata_i,
    input  logic [INDEX_BITS-1:0]       rindex_i,
    output logic [TAG_BITS-1:0]         rtag_o,
    output logic [ICACHE_LINE_BITS-1:0] rdata_o
);

    logic [TAG_BITS-1:0]         tag_q  [NUM_SETS];
    logic [ICACHE_LINE_BITS-1:0] data_q [NUM_SETS];

    // No reset: entries are only trusted once the parent's valid bit is set.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[windex_i]  <= wtag_i;
            data_q[windex_i] <= wdata_i;
        end
    end

    assign rtag_o  = tag_q[rindex_i];
    assign rdata_o = data_q[rindex_i];

endmodule

// File: rtl/icache_line_responder.sv
// Direct-mapped I-cache responder: serves 128-bit lines to fetch, refills misses in 4 word beats.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_EN.
module icache_line_responder
    import icache_line_responder_pkg::*;
#(
    parameter  int ADDR_WIDTH = `INST_ADDR_WIDTH,
    parameter  int NUM_SETS   = 64,
    localparam int INDEX_BITS = $clog2(NUM_SETS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ic_req,
    input  logic [ADDR_WIDTH-1:0]       ic_paddr,
    input  logic                        ic_abort,
    input  logic                        ic_inval,
    output logic [ICACHE_LINE_BITS-1:0] ic_rdata_line,
    output logic                        ic_valid,
    output logic                        ic_stall,
    output logic                        mem_req,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic                        mem_gnt,
    input  logic                        mem_rvalid,
    input  logic [`INST_WIDTH-1:0]      mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]                 perf_hit_cnt,
    output logic [31:0]                 perf_miss_cnt
`endif
);

    localparam int LINE_ADDR_BITS = ADDR_WIDTH - ICACHE_OFFSET_BITS;
    localparam int TAG_BITS       = LINE_ADDR_BITS - INDEX_BITS;

    ic_state_e                                   state_q;
    logic [NUM_SETS-1:0]                         valid_q;
    logic [LINE_ADDR_BITS-1:0]                   line_q;
    logic [ICACHE_LINE_WORDS-1:0][`INST_WIDTH-1:0] fill_q;
    logic [1:0]                                  beat_q;
    logic                                        abort_q;
    logic                                        inval_pend_q;

    logic [INDEX_BITS-1:0]       req_index;
    logic [TAG_BITS-1:0]         req_tag;
    logic [TAG_BITS-1:0]         rd_tag;
    logic [ICACHE_LINE_BITS-1:0] rd_data;
    logic                        hit;
    logic                        fill_done;
    logic [ICACHE_LINE_BITS-1:0] fill_wdata;
    logic                        resp_ok;
    logic                        unused_paddr_offset;

    assign unused_paddr_offset = ^ic_paddr[ICACHE_OFFSET_BITS-1:0];

    assign req_index  = line_q[INDEX_BITS-1:0];
    assign req_tag    = line_q[LINE_ADDR_BITS-1:INDEX_BITS];
    assign hit        = valid_q[req_index] && (rd_tag == req_tag);
    assign fill_done  = (state_q == ST_REFILL_DATA) && mem_rvalid && (beat_q == 2'd3);
    assign fill_wdata = {mem_rdata, fill_q[2], fill_q[1], fill_q[0]};

    icache_tag_data_array #(
        .NUM_SETS   (NUM_SETS),
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .we_i     (fill_done),
        .windex_i (req_index),
        .wtag_i   (req_tag),
        .wdata_i  (fill_wdata),
        .rindex_i (req_index),
        .rtag_o   (rd_tag),
        .rdata_o  (rd_data)
    );

    // Abort and invalidate requests arriving mid-transaction are remembered, never acted on early.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            line_q       <= '0;
            fill_q       <= '0;
            beat_q       <= 2'd0;
            abort_q      <= 1'b0;
            inval_pend_q <= 1'b0;
        end else begin
            if (state_q != ST_IDLE) begin
                if (ic_abort) abort_q <= 1'b1;
                if (ic_inval) inval_pend_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (inval_pend_q || ic_inval) begin
                        valid_q      <= '0;
                        inval_pend_q <= 1'b0;
                    end else if (ic_req && !ic_abort) begin
                        line_q  <= ic_paddr[ADDR_WIDTH-1:ICACHE_OFFSET_BITS];
                        abort_q <= 1'b0;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    state_q <= hit ? ST_IDLE : ST_REFILL_REQ;
                end
                ST_REFILL_REQ: begin
                    if (mem_gnt) begin
                        beat_q  <= 2'd0;
                        state_q <= ST_REFILL_DATA;
                    end
                end
                ST_REFILL_DATA: begin
                    if (mem_rvalid) begin
                        fill_q[beat_q] <= mem_rdata;
                        beat_q         <= beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            valid_q[req_index] <= 1'b1;
                            state_q            <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A late abort in the response cycle itself must still squash the pulse.
    assign resp_ok       = !(abort_q || ic_abort);
    assign ic_valid      = resp_ok && (((state_q == ST_LOOKUP) && hit) || (state_q == ST_RESP));
    assign ic_rdata_line = !ic_valid ? '0 : ((state_q == ST_RESP) ? fill_q : rd_data);
    assign ic_stall      = (state_q == ST_REFILL_REQ) || (state_q == ST_REFILL_DATA);
    assign mem_req       = (state_q == ST_REFILL_REQ);
    assign mem_addr      = mem_req ? {line_q, {ICACHE_OFFSET_BITS{1'b0}}} : '0;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
            else     miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_line_responder.sv
// Self-checking bench for icache_line_responder: vector table plus hand-written abort/inval/reset sequences.
module tb_icache_line_responder;

    logic         clk;
    logic         rst_n;
    logic         ic_req;
    logic [31:0]  ic_paddr;
    logic         ic_abort;
    logic         ic_inval;
    logic [127:0] ic_rdata_line;
    logic         ic_valid;
    logic         ic_stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0]  perfHitCnt;
    logic [31:0]  perfMissCnt;
`endif

    int testsRun  = 0;
    int testsFail = 0;
    logic [127:0] sbQ[$];

    icache_line_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ic_req        (ic_req),
        .ic_paddr      (ic_paddr),
        .ic_abort      (ic_abort),
        .ic_inval      (ic_inval),
        .ic_rdata_line (ic_rdata_line),
        .ic_valid      (ic_valid),
        .ic_stall      (ic_stall),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit_cnt  (perfHitCnt),
        .perf_miss_cnt (perfMissCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [31:0] addr;
        bit          expHit;
        int          abortBeat;
        int          invalBeat;
        bit          expDeliver;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] lineOf(input logic [31:0] a);
        return {a[31:4], 4'h0};
    endfunction

    // Backing memory contents: the 0x100 line is fixed, others derive from the line address.
    function automatic logic [31:0] memWord(input logic [31:0] lineAddr, input int k);
        if (lineAddr == 32'h0000_0100) return 32'(k + 1) * 32'h11;
        return lineAddr ^ {8'(k + 1), 24'h00BEEF};
    endfunction

    function automatic logic [127:0] expLine(input logic [31:0] a);
        logic [31:0] la;
        la = lineOf(a);
        return {memWord(la, 3), memWord(la, 2), memWord(la, 1), memWord(la, 0)};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every ic_valid pulse must match the oldest expected line.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (ic_valid === 1'b1) begin
                if (sbQ.size() == 0) begin
                    testsRun++;
                    testsFail++;
                    $display("[TB] FAIL unexpectedValid: got ic_valid=1 with line 0x%0h, expected no response at %0t",
                             ic_rdata_line, $time);
                end else begin
                    checkOutput("respLine", ic_rdata_line, sbQ.pop_front());
                end
            end
        end
    end

    task automatic waitMemReq(input logic [31:0] addr, output bit found);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            #4;
            if (mem_req === 1'b1) found = 1'b1;
        end
        checkOutput("memReqSeen", {127'd0, found}, 128'd1);
        if (found) begin
            checkOutput("memAddr", {96'd0, mem_addr}, {96'd0, lineOf(addr)});
            checkOutput("stallInReq", {127'd0, ic_stall}, 128'd1);
            mem_gnt = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input bit expHit, input int abortBeat,
                                 input int invalBeat, input bit expDeliver);
        bit found;
        @(negedge clk);
        ic_req   = 1'b1;
        ic_paddr = addr;
        if (expDeliver) sbQ.push_back(expLine(addr));
        @(negedge clk);
        ic_req   = 1'b0;
        ic_paddr = 32'h0;
        #4;
        checkOutput("lookupValid", {127'd0, ic_valid}, {127'd0, expHit && expDeliver});
        checkOutput("lookupMemReq", {127'd0, mem_req}, 128'd0);
        if (!expHit) begin
            waitMemReq(addr, found);
            if (!found) return;
            @(negedge clk);
            mem_gnt = 1'b0;
            for (int b = 0; b < 4; b++) begin
                mem_rvalid = 1'b1;
                mem_rdata  = memWord(lineOf(addr), b);
                ic_abort   = (b == abortBeat);
                ic_inval   = (b == invalBeat);
                #4;
                checkOutput("stallInData", {127'd0, ic_stall}, 128'd1);
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            ic_abort   = 1'b0;
            ic_inval   = 1'b0;
            #4;
            checkOutput("respValid", {127'd0, ic_valid}, {127'd0, expDeliver});
            checkOutput("respStall", {127'd0, ic_stall}, 128'd0);
        end
        @(negedge clk);
        #4;
        checkOutput("validPulseEnds", {127'd0, ic_valid}, 128'd0);
        checkOutput("idleMemReq", {127'd0, mem_req}, 128'd0);
    endtask

    initial begin
        bit found;
        vecs[0]  = '{32'h0000_0100, 1'b0, -1, -1, 1'b1};
        vecs[1]  = '{32'h0000_0108, 1'b1, -1, -1, 1'b1};
        vecs[2]  = '{32'h0000_0500, 1'b0, -1, -1, 1'b1};
        vecs[3]  = '{32'h0000_0100, 1'b0, -1, -1, 1'b1};
        vecs[4]  = '{32'h0000_0104, 1'b1, -1, -1, 1'b1};
        vecs[5]  = '{32'h0000_03F0, 1'b0, -1, -1, 1'b1};
        vecs[6]  = '{32'h0000_03F8, 1'b1, -1, -1, 1'b1};
        vecs[7]  = '{32'h0000_0500, 1'b0,  1, -1, 1'b0};
        vecs[8]  = '{32'h0000_050C, 1'b1, -1, -1, 1'b1};
        vecs[9]  = '{32'hFFFF_FFF0, 1'b0, -1, -1, 1'b1};
        vecs[10] = '{32'h0000_03F0, 1'b0, -1,  2, 1'b1};
        vecs[11] = '{32'h0000_03F0, 1'b0, -1, -1, 1'b1};
        vecs[12] = '{32'h0000_050C, 1'b0, -1, -1, 1'b1};

        rst_n      = 1'b0;
        ic_req     = 1'b0;
        ic_paddr   = 32'h0;
        ic_abort   = 1'b0;
        ic_inval   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) @(negedge clk);
        #4;
        checkOutput("rstValid", {127'd0, ic_valid}, 128'd0);
        checkOutput("rstStall", {127'd0, ic_stall}, 128'd0);
        checkOutput("rstMemReq", {127'd0, mem_req}, 128'd0);
        checkOutput("rstMemAddr", {96'd0, mem_addr}, 128'd0);
        checkOutput("rstLine", ic_rdata_line, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        checkOutput("testPlanLine", expLine(32'h100), 128'h00000044_00000033_00000022_00000011);

        for (int i = 0; i < 13; i++)
            applyStimulus(vecs[i].addr, vecs[i].expHit, vecs[i].abortBeat, vecs[i].invalBeat, vecs[i].expDeliver);

        // Abort raised in the hit cycle itself suppresses the response; the next hit is clean again.
        @(negedge clk);
        ic_req   = 1'b1;
        ic_paddr = 32'h0000_0500;
        @(negedge clk);
        ic_req   = 1'b0;
        ic_abort = 1'b1;
        #4;
        checkOutput("abortHitValid", {127'd0, ic_valid}, 128'd0);
        checkOutput("abortHitLine", ic_rdata_line, 128'd0);
        @(negedge clk);
        ic_abort = 1'b0;
        applyStimulus(32'h0000_0508, 1'b1, -1, -1, 1'b1);

        // Invalidate wins over a simultaneous request, and empties the cache.
        @(negedge clk);
        ic_req   = 1'b1;
        ic_inval = 1'b1;
        ic_paddr = 32'h0000_0500;
        @(negedge clk);
        ic_req   = 1'b0;
        ic_inval = 1'b0;
        #4;
        checkOutput("invalPrioValid", {127'd0, ic_valid}, 128'd0);
        @(negedge clk);
        #4;
        checkOutput("invalPrioMemReq", {127'd0, mem_req}, 128'd0);
        applyStimulus(32'h0000_0500, 1'b0, -1, -1, 1'b1);

        // Reset mid-refill: the refill is abandoned and late beats are ignored.
        @(negedge clk);
        ic_req   = 1'b1;
        ic_paddr = 32'h0000_0200;
        @(negedge clk);
        ic_req = 1'b0;
        waitMemReq(32'h0000_0200, found);
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memWord(32'h200, b);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 2; b < 4; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memWord(32'h200, b);
            #4;
            checkOutput("lateBeatValid", {127'd0, ic_valid}, 128'd0);
            checkOutput("lateBeatStall", {127'd0, ic_stall}, 128'd0);
            checkOutput("lateBeatMemReq", {127'd0, mem_req}, 128'd0);
            checkOutput("lateBeatLine", ic_rdata_line, 128'd0);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        #4;
        checkOutput("postRstValid", {127'd0, ic_valid}, 128'd0);
        applyStimulus(32'h0000_0200, 1'b0, -1, -1, 1'b1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardDrained", 128'(sbQ.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/icache_line_responder.md
Name: icache_line_responder

Overview:
- Direct-mapped instruction cache; the responder end of the fetch-stage line interface (ic_req / ic_paddr in, ic_rdata_line / ic_valid / ic_stall out).
- Returns one aligned 128-bit line (4 instruction words) per accepted request.
- On a miss, refills the line from a 32-bit word-serial memory port in 4 beats.
- Sits between the fetch stage and the memory/L2 arbiter.

Parameters:
ADDR_WIDTH, 32, physical address width; matches `INST_ADDR_WIDTH
NUM_SETS, 64, number of lines; power of 2, at least 2
INDEX_BITS, $clog2(NUM_SETS), set index width; derived, do not override

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
ic_req  in  1  line request; level; ic_paddr valid while high
ic_paddr  in  ADDR_WIDTH  request address; bits [3:0] ignored
ic_abort  in  1  kill the in-flight response; tied to fetch flush or redirect
ic_inval  in  1  one-cycle pulse; invalidate the whole cache (fence.i)
ic_rdata_line  out  128  line data; word k at bits [32k+31:32k]
ic_valid  out  1  one-cycle pulse; ic_rdata_line valid
ic_stall  out  1  high while a refill is outstanding
mem_req  out  1  refill request; held until grant
mem_addr  out  ADDR_WIDTH  line-aligned refill address, bits [3:0] = 0
mem_gnt  in  1  refill request accepted
mem_rvalid  in  1  refill data beat valid
mem_rdata  in  32  refill data beat

Behaviour:
- Address split: offset = [3:0]; index = [INDEX_BITS+3:4]; tag = [ADDR_WIDTH-1:INDEX_BITS+4].
- Storage: valid bit per set (flops); tag array and data array per set.
- Reset (synchronous, rst_n low at the clock edge): state IDLE; all valid bits 0; abort_flag 0; inval_pend 0; beat counter 0. Outputs: ic_valid 0, ic_stall 0, mem_req 0, mem_addr 0, ic_rdata_line 0.
- Reset applied mid-refill abandons the refill. No ic_valid follows. Memory beats that arrive afterwards are ignored.
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, RESP.
- IDLE:
  - If inval_pend or ic_inval: clear all valid bits and inval_pend; stay IDLE. Invalidation has priority over a request in the same cycle.
  - Else if ic_req and not ic_abort: latch ic_paddr into req_addr; clear abort_flag; go to LOOKUP.
- LOOKUP:
  - Hit (valid[index] and tag match): ic_valid = !(abort_flag | ic_abort); ic_rdata_line = stored line; go to IDLE.
  - Hit latency: request sampled at edge N, ic_valid high in cycle N+1.
  - Miss: go to REFILL_REQ.
  - ic_req is not sampled in LOOKUP, REFILL_*, or RESP. The requester keeps ic_req high until served.
- REFILL_REQ: mem_req = 1; mem_addr = {req_addr[ADDR_WIDTH-1:4], 4'b0}. On mem_gnt: beat count = 0; go to REFILL_DATA.
- REFILL_DATA:
  - Each mem_rvalid writes mem_rdata into word[beat] of the fill buffer; beat increments (2-bit).
  - On the 4th beat: write tag and data; set valid[index]; go to RESP.
  - mem_rvalid outside REFILL_DATA is ignored.
- RESP: ic_valid = !(abort_flag | ic_abort); ic_rdata_line = fill buffer; go to IDLE.
- ic_stall = 1 in REFILL_REQ and REFILL_DATA; 0 otherwise.
- ic_rdata_line = 0 whenever ic_valid is 0.
- Abort:
  - ic_abort high in LOOKUP, REFILL_*, or RESP sets abort_flag. The response is suppressed.
  - A refill in progress still completes and installs the line; the memory transaction is never cancelled.
  - A suppressed response never raises ic_valid; this prevents a stale line from being matched against a new requester epoch.
- ic_inval while not IDLE sets inval_pend; it is applied on the next IDLE cycle. A line installed by the concurrent refill is also invalidated, but its response (if not aborted) is still delivered.
- Back-to-back: a hit completes one request per 2 cycles. After a hit, IDLE may accept a new ic_req on the following edge.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- When defined, adds output ports perf_hit_cnt [31:0] and perf_miss_cnt [31:0]:
  - They increment on the LOOKUP exit edge (hit or miss respectively), aborted requests included.
  - Both reset to 0 and wrap at 2^32.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared define file: ICACHE_LINE_BITS (128), ICACHE_LINE_WORDS (4), ICACHE_OFFSET_BITS (4), FSM state encodings.
- Interface widths use the existing `INST_ADDR_WIDTH and `INST_WIDTH.
- One sub-module, icache_tag_data_array:
  - NUM_SETS entries of {tag, 128-bit data}.
  - Combinational read by index; synchronous write port.
  - Valid bits stay in the parent so invalidation is single-cycle.

Test Plan:
- Reset, then ic_req with ic_paddr=0x0000_0100 (cold) -> mem_req with mem_addr=0x100; after grant, 4 beats 0x11,0x22,0x33,0x44 -> ic_valid for one cycle with line 0x00000044_00000033_00000022_00000011; ic_stall high throughout the refill.
- Same address again as 0x0000_0108 -> ic_valid exactly 1 cycle after the sampling edge; same line returned; mem_req stays 0.
- Conflict: 0x0000_0500 maps to index 16 (same set as 0x100 with NUM_SETS=64) -> miss and refill; then 0x100 misses again.
- ic_abort pulsed during the 2nd refill beat -> refill completes; ic_valid stays 0; a following request to the same line hits with no mem_req.
- ic_inval pulsed mid-refill -> response delivered; the next request to that line misses (mem_req reasserted).
- rst_n low during REFILL_DATA, then late mem_rvalid beats -> no ic_valid; all outputs 0; the line is not valid afterwards.
